// File: rtl/register_rename_unit_if.sv
// Rename-stage bus: decoded instruction in, renamed tags out, plus retire and FU writeback.
// Macro RENAME_PERF_EN adds the stall_cycles_out counter signal.
interface register_rename_unit_if #(
   parameter int ARCH_SIZE = 5,
   parameter int PHYS_SIZE = 6,
   parameter int PHYS_REGS = 64
);
   logic                 valid_in;
   logic [ARCH_SIZE-1:0] rs1_arch_in;
   logic [ARCH_SIZE-1:0] rs2_arch_in;
   logic [ARCH_SIZE-1:0] rd_arch_in;
   logic                 rd_write_in;
   logic                 stall_in;
   logic                 retire_valid_in;
   logic [PHYS_SIZE-1:0] retire_tag_in;
   logic [2:0]           fu_flag_in;
   logic [PHYS_SIZE-1:0] fu_tag0_in;
   logic [PHYS_SIZE-1:0] fu_tag1_in;
   logic [PHYS_SIZE-1:0] fu_tag2_in;
   logic                 valid_out;
   logic [PHYS_SIZE-1:0] rs1_out;
   logic [PHYS_SIZE-1:0] rs2_out;
   logic [PHYS_SIZE-1:0] rd_out;
   logic [PHYS_SIZE-1:0] old_rd_out;
   logic                 rs1_ready_out;
   logic                 rs2_ready_out;
   logic [PHYS_REGS-1:0] preg_ready_out;
   logic                 stall_out;
   logic [PHYS_SIZE:0]   free_count_out;
`ifdef RENAME_PERF_EN
   logic [31:0]          stall_cycles_out;
`endif

   // Handshake: an instruction is taken when valid_in && !stall_in && !(needs a tag && free list empty);
   // its result appears with valid_out one cycle later and is held while stall_in is high.
   modport master (
      output valid_in, rs1_arch_in, rs2_arch_in, rd_arch_in, rd_write_in, stall_in,
      output retire_valid_in, retire_tag_in, fu_flag_in, fu_tag0_in, fu_tag1_in, fu_tag2_in,
      input  valid_out, rs1_out, rs2_out, rd_out, old_rd_out, rs1_ready_out, rs2_ready_out,
      input  preg_ready_out, stall_out, free_count_out
`ifdef RENAME_PERF_EN
      , input stall_cycles_out
`endif
   );

   modport slave (
      input  valid_in, rs1_arch_in, rs2_arch_in, rd_arch_in, rd_write_in, stall_in,
      input  retire_valid_in, retire_tag_in, fu_flag_in, fu_tag0_in, fu_tag1_in, fu_tag2_in,
      output valid_out, rs1_out, rs2_out, rd_out, old_rd_out, rs1_ready_out, rs2_ready_out,
      output preg_ready_out, stall_out, free_count_out
`ifdef RENAME_PERF_EN
      , output stall_cycles_out
`endif
   );
endinterface

// File: rtl/register_rename_unit.sv
// Register rename: RAT + circular free list + per-tag ready bits, results registered (latency 1).
// Macro RENAME_PERF_EN adds a saturating count of cycles with valid_in while the free list is empty.
module register_rename_unit #(
   parameter int ARCH_SIZE = 5,
   parameter int ARCH_REGS = 32,
   parameter int PHYS_SIZE = 6,
   parameter int PHYS_REGS = 64
) (
   input logic                  clk,
   input logic                  rst,
   register_rename_unit_if.slave bus
);
   localparam logic [PHYS_SIZE:0] FL_FULL = (PHYS_SIZE+1)'(PHYS_REGS);

   logic [PHYS_SIZE-1:0] r_rat [ARCH_REGS];
   logic [PHYS_SIZE-1:0] r_fl  [PHYS_REGS];
   logic [PHYS_SIZE-1:0] r_head, r_tail;
   logic [PHYS_SIZE:0]   r_count;
   logic [PHYS_REGS-1:0] r_ready;
   logic                 r_valid, r_rs1_rdy, r_rs2_rdy;
   logic [PHYS_SIZE-1:0] r_rs1, r_rs2, r_rd, r_old_rd;

   logic                 w_need_alloc, w_empty, w_accept, w_pop, w_push;
   logic [PHYS_SIZE-1:0] w_rs1_tag, w_rs2_tag, w_head_tag;
   logic                 w_rs1_rdy, w_rs2_rdy;
   logic [PHYS_REGS-1:0] w_ready_nxt;
   logic [PHYS_SIZE-1:0] w_fu_tag [3];

   assign w_need_alloc = bus.rd_write_in && (bus.rd_arch_in != '0);
   assign w_empty      = (r_count == '0);
   assign w_accept     = bus.valid_in && !bus.stall_in && !(w_need_alloc && w_empty);
   assign w_pop        = w_accept && w_need_alloc;
   assign w_push       = bus.retire_valid_in && (bus.retire_tag_in != '0) && (r_count < FL_FULL);
   assign w_rs1_tag    = r_rat[bus.rs1_arch_in];
   assign w_rs2_tag    = r_rat[bus.rs2_arch_in];
   assign w_head_tag   = r_fl[r_head];
   assign w_fu_tag[0]  = bus.fu_tag0_in;
   assign w_fu_tag[1]  = bus.fu_tag1_in;
   assign w_fu_tag[2]  = bus.fu_tag2_in;

   // Source is ready if already written back, being written back this cycle, or x0's tag 0.
   always_comb begin
      w_rs1_rdy = r_ready[w_rs1_tag] || (w_rs1_tag == '0);
      w_rs2_rdy = r_ready[w_rs2_tag] || (w_rs2_tag == '0);
      for (int k = 0; k < 3; k++) begin
         if (bus.fu_flag_in[k] && (w_fu_tag[k] == w_rs1_tag)) w_rs1_rdy = 1'b1;
         if (bus.fu_flag_in[k] && (w_fu_tag[k] == w_rs2_tag)) w_rs2_rdy = 1'b1;
      end
   end

   // Allocation clear is applied after writeback sets so it wins on a same-tag collision.
   always_comb begin
      w_ready_nxt = r_ready;
      for (int k = 0; k < 3; k++) begin
         if (bus.fu_flag_in[k]) w_ready_nxt[w_fu_tag[k]] = 1'b1;
      end
      if (w_pop) w_ready_nxt[w_head_tag] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REGS; i++) r_rat[i] <= PHYS_SIZE'(i);
         for (int i = 0; i < PHYS_REGS; i++) r_fl[i] <= PHYS_SIZE'(i + ARCH_REGS);
         r_head    <= '0;
         r_tail    <= PHYS_SIZE'(ARCH_REGS);
         r_count   <= (PHYS_SIZE+1)'(ARCH_REGS);
         r_ready   <= '1;
         r_valid   <= 1'b0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_old_rd  <= '0;
         r_rs1_rdy <= 1'b0;
         r_rs2_rdy <= 1'b0;
      end else begin
         r_ready <= w_ready_nxt;
         if (w_pop) begin
            r_rat[bus.rd_arch_in] <= w_head_tag;
            r_head                <= r_head + PHYS_SIZE'(1);
         end
         if (w_push) begin
            r_fl[r_tail] <= bus.retire_tag_in;
            r_tail       <= r_tail + PHYS_SIZE'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PHYS_SIZE+1)'(1);
            2'b01:   r_count <= r_count - (PHYS_SIZE+1)'(1);
            default: r_count <= r_count;
         endcase
         if (!bus.stall_in) begin
            r_valid <= w_accept;
            if (w_accept) begin
               r_rs1     <= w_rs1_tag;
               r_rs2     <= w_rs2_tag;
               r_rs1_rdy <= w_rs1_rdy;
               r_rs2_rdy <= w_rs2_rdy;
               r_rd      <= w_pop ? w_head_tag : '0;
               r_old_rd  <= w_pop ? r_rat[bus.rd_arch_in] : '0;
            end
         end
      end
   end

`ifdef RENAME_PERF_EN
   logic [31:0] r_stall_cycles;
   always_ff @(posedge clk) begin
      if (rst)                                             r_stall_cycles <= '0;
      else if (bus.valid_in && w_empty && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
   end
   assign bus.stall_cycles_out = r_stall_cycles;
`endif

   assign bus.valid_out      = r_valid;
   assign bus.rs1_out        = r_rs1;
   assign bus.rs2_out        = r_rs2;
   assign bus.rd_out         = r_rd;
   assign bus.old_rd_out     = r_old_rd;
   assign bus.rs1_ready_out  = r_rs1_rdy;
   assign bus.rs2_ready_out  = r_rs2_rdy;
   assign bus.preg_ready_out = r_ready;
   assign bus.stall_out      = w_empty;
   assign bus.free_count_out = r_count;
endmodule

// File: doc/register_rename_unit.md
Name: register_rename_unit

Overview:
- Rename stage directly upstream of the unified issue queue.
- Maps 5-bit architectural registers to 6-bit physical tags using a register alias table (RAT) and a circular free-list FIFO.
- Tracks per-physical-register ready bits, set by FU writeback.
- Delivers renamed tags, ready status and the old destination mapping (for later freeing) one cycle after acceptance.

Parameters:
- ARCH_SIZE, 5, architectural register index width
- ARCH_REGS, 32, architectural register count
- PHYS_SIZE, 6, physical tag width (matches issue queue AR_SIZE)
- PHYS_REGS, 64, physical register count

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- valid_in  in  1  decoded instruction present
- rs1_arch_in  in  ARCH_SIZE  source 1 architectural index
- rs2_arch_in  in  ARCH_SIZE  source 2 architectural index
- rd_arch_in  in  ARCH_SIZE  destination architectural index
- rd_write_in  in  1  instruction writes rd
- stall_in  in  1  downstream (issue queue) full; hold
- retire_valid_in  in  1  free one physical tag
- retire_tag_in  in  PHYS_SIZE  tag being freed
- fu_flag_in  in  3  FU0..FU2 writeback valid
- fu_tag0_in / fu_tag1_in / fu_tag2_in  in  PHYS_SIZE each  writeback tags
- valid_out  out  1  renamed instruction valid this cycle
- rs1_out / rs2_out / rd_out / old_rd_out  out  PHYS_SIZE each  renamed tags
- rs1_ready_out / rs2_ready_out  out  1 each  source ready at rename
- preg_ready_out  out  PHYS_REGS  ready vector, bit i = tag i ready
- stall_out  out  1  free list empty; upstream must hold
- free_count_out  out  PHYS_SIZE+1  entries in free list

Behaviour:
- Reset (rst=1 at edge):
  - RAT[i]=i.
  - Free list holds tags 32..63 in order: head=0, count=32.
  - preg_ready all 1.
  - All outputs 0 except preg_ready_out=all ones and free_count_out=32.
- need_alloc = rd_write_in && rd_arch_in!=0.
- accept = valid_in && !stall_in && !(need_alloc && count==0).
- stall_out = (count==0), combinational from registered count.
- Latency 1: outputs are registered, valid_out=1 the cycle after accept.
- stall_in=1: all outputs hold previous values; valid_out holds; no RAT/free-list change from rename.
- Not stalled and not accepted: valid_out=0 next cycle; tag outputs are don't-care but hold.
- On accept:
  - rs1_out=RAT[rs1_arch_in]; rs2_out=RAT[rs2_arch_in]. Read occurs before this instruction's own update, so rs==rd yields the old tag.
  - If need_alloc: rd_out=free head, old_rd_out=RAT[rd_arch_in], RAT[rd_arch_in]<=head, head++ (wraps mod PHYS_REGS), count--, preg_ready[head]<=0.
  - Else: rd_out=0, old_rd_out=0, no pop.
- Source ready: preg_ready[tag] OR (any fu_flag_in[k] with fu_tagk_in==tag) in the same cycle (writeback bypass). Tag 0 is always ready.
- Writeback: for each k with fu_flag_in[k], preg_ready[fu_tagk_in]<=1. If the same tag is allocated in the same cycle, the allocation clear wins.
- Retire: if retire_valid_in && retire_tag_in!=0 && count<PHYS_REGS, push at tail (wraps), count++. Tag 0 or a push when full is ignored.
- Simultaneous pop+push: both occur, count unchanged. A push while count==0 does not permit allocation that same cycle.
- x0: never allocated, never freed, RAT[0] fixed at 0.
- Reset mid-stream: all in-flight state discarded; valid_out=0 the following cycle.

Optional Feature:
- Macro RENAME_PERF_EN.
- Defined: adds output stall_cycles_out (32-bit), counting cycles with valid_in && stall_out. Saturates at 0xFFFFFFFF; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then rename add x5,x1,x2 (rd_write=1) -> next cycle valid_out=1, rs1_out=1, rs2_out=2, rd_out=32, old_rd_out=5, rs1/rs2_ready=1, preg_ready_out[32]=0, free_count_out=31.
- Follow with add x6,x5,x5 -> rs1_out=rs2_out=32, ready=0, rd_out=33. Then fu_flag_in=3'b010, fu_tag1_in=32 -> preg_ready_out[32]=1 next cycle.
- Rename with fu_flag_in[0]=1, fu_tag0_in=33 in the same cycle as source x6 -> rs1_ready_out=1 (bypass).
- Issue 32 allocating renames with no retire -> free_count_out=0, stall_out=1. Next valid_in with rd_write is not accepted (valid_out=0). Retire tag 40 -> following rename gets rd_out=40.
- Pop and retire tag 5 in the same cycle with count=10 -> count stays 10; tag 5 appears at head after wrap-around.
- stall_in=1 for 3 cycles with valid_in=1 -> outputs frozen, free_count_out unchanged. rd_arch_in=0 with rd_write=1 -> rd_out=0, no pop.
